lcd_cmd_sequencer: RTL

//  Buffers a host-supplied script of 3-bit image commands in a small FIFO and issues them to the
//  LCD image controller over its cmd/cmd_valid/busy/done handshake. Issues one command at a time.

---
 rtl/lcd_pkg.sv | 24 ++
 rtl/cmd_fifo.sv | 63 ++++++
 rtl/lcd_cmd_sequencer.sv | 119 +++++++++++
 3 files changed

// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD display path: command codes and sequencer states.
package lcd_pkg;

   typedef logic [2:0] cmd_t;

   // Command codes understood by the LCD image controller
   localparam cmd_t CMD_WRITE = 3'd0;
   localparam cmd_t CMD_SHU   = 3'd1;
   localparam cmd_t CMD_SHD   = 3'd2;
   localparam cmd_t CMD_SHL   = 3'd3;
   localparam cmd_t CMD_SHR   = 3'd4;
   localparam cmd_t CMD_AVG   = 3'd5;
   localparam cmd_t CMD_MIRX  = 3'd6;
   localparam cmd_t CMD_MIRY  = 3'd7;

   // Sequencer state encodings
   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_WAIT_RDY = 3'd1;
   localparam logic [2:0] S_ISSUE    = 3'd2;
   localparam logic [2:0] S_GAP      = 3'd3;
   localparam logic [2:0] S_WAIT_WR  = 3'd4;
   localparam logic [2:0] S_FINISH   = 3'd5;

endpackage

// File: rtl/cmd_fifo.sv
// Small synchronous FIFO with occupancy count. The head entry is visible
// combinationally so the sequencer can latch it on the cycle it issues.
module cmd_fifo #(
   parameter int DEPTH = 16,
   parameter int AW    = 4,
   parameter int W     = 3
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          push,
   input  logic [W-1:0]  push_data,
   input  logic          pop,
   output logic [W-1:0]  head,
   output logic [AW:0]   count
);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr_reg;
   logic [AW-1:0] rd_ptr_reg;
   logic [AW:0]   count_reg;
   logic [AW:0]   count_next;
   logic          pop_ok;

   // A pop on an empty FIFO is never requested, but is masked so pointers stay coherent
   assign pop_ok = pop && (count_reg != '0);
   assign head   = mem[rd_ptr_reg];
   assign count  = count_reg;

   // Occupancy: simultaneous push and pop leaves the count unchanged
   always_comb begin
      count_next = count_reg;
      case ({push, pop_ok})
         2'b10:   count_next = count_reg + 1'b1;
         2'b01:   count_next = count_reg - 1'b1;
         default: count_next = count_reg;
      endcase
   end

   // Storage array is left unreset; only the pointers define validity
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr_reg] <= push_data;
      end
   end

   // Pointers wrap naturally at DEPTH (power of two)
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         end
         if (pop_ok) begin
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         end
         count_reg <= count_next;
      end
   end

endmodule

// File: rtl/lcd_cmd_sequencer.sv
// Buffers a host command script and issues it, one command at a time, to the
// LCD image controller. A Write ends the script once the controller reports done.
module lcd_cmd_sequencer
   import lcd_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic          push_valid,
   input  logic [2:0]    push_cmd,
   output logic          push_ready,
   input  logic          lcd_busy,
   input  logic          lcd_done,
   output logic [2:0]    cmd,
   output logic          cmd_valid,
   output logic [AW:0]   fifo_count,
   output logic          seq_done,
   output logic          overflow
);

   localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

   logic [2:0]  state_reg;
   logic [2:0]  state_next;
   logic [2:0]  cmd_reg;
   logic        cmd_valid_reg;
   logic        seq_done_reg;
   logic        overflow_reg;
   logic        push_en;
   logic        pop_en;
   logic [2:0]  head;

   // Ready derives from registered count only, so a pop never frees a slot in the same cycle
   assign push_ready = (fifo_count != FULL_COUNT) && (state_reg != S_FINISH);
   assign push_en    = push_valid && push_ready;
   assign pop_en     = (state_reg == S_ISSUE);

   assign cmd        = cmd_reg;
   assign cmd_valid  = cmd_valid_reg;
   assign seq_done   = seq_done_reg;
   assign overflow   = overflow_reg;

   cmd_fifo #(
      .DEPTH (DEPTH),
      .AW    (AW),
      .W     (3)
   ) u_cmd_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push_en),
      .push_data (push_cmd),
      .pop       (pop_en),
      .head      (head),
      .count     (fifo_count)
   );

   // Next-state logic for the issue handshake
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_IDLE: begin
            if (start) begin
               state_next = S_WAIT_RDY;
            end
         end
         S_WAIT_RDY: begin
            if (!lcd_busy && (fifo_count != '0)) begin
               state_next = S_ISSUE;
            end
         end
         S_ISSUE: begin
            // cmd_reg holds the head being popped this cycle
            state_next = (cmd_reg == CMD_WRITE) ? S_WAIT_WR : S_GAP;
         end
         S_GAP: begin
            // Lets the controller raise busy for the command just issued
            state_next = S_WAIT_RDY;
         end
         S_WAIT_WR: begin
            if (lcd_done) begin
               state_next = S_FINISH;
            end
         end
         S_FINISH: begin
            state_next = S_FINISH;
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   // State and output registers; the strobe is high exactly while in ISSUE
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg     <= S_IDLE;
         cmd_reg       <= CMD_WRITE;
         cmd_valid_reg <= 1'b0;
         seq_done_reg  <= 1'b0;
         overflow_reg  <= 1'b0;
      end else begin
         state_reg     <= state_next;
         cmd_valid_reg <= (state_next == S_ISSUE);
         if ((state_reg == S_WAIT_RDY) && (state_next == S_ISSUE)) begin
            cmd_reg <= head;
         end
         if ((state_reg == S_WAIT_WR) && lcd_done) begin
            seq_done_reg <= 1'b1;
         end
         if (push_valid && !push_ready) begin
            overflow_reg <= 1'b1;
         end
      end
   end

endmodule
